// File: rtl/mcu_pc_sequencer_if.sv
// Request/status bundle between an instruction fetch front end and the PC sequencer.
// The master issues flow-control requests. The slave is the sequencer, which reports PC and stack status.
interface mcu_pc_sequencer_if #(
  parameter int PC_WIDTH    = 8,
  parameter int STACK_DEPTH = 4
);
  localparam int DW = $clog2(STACK_DEPTH) + 1;

  logic [PC_WIDTH-1:0] resetPC;
  logic                i_stall;
  logic                i_jump;
  logic                i_call;
  logic                i_ret;
  logic [PC_WIDTH-1:0] i_target;
  logic [PC_WIDTH-1:0] currentPC;
  logic [DW-1:0]       o_depth;
  logic                o_stackFull;
  logic                o_stackEmpty;
  logic                o_fault;

  modport master (
    output resetPC, i_stall, i_jump, i_call, i_ret, i_target,
    input  currentPC, o_depth, o_stackFull, o_stackEmpty, o_fault
  );

  modport slave (
    input  resetPC, i_stall, i_jump, i_call, i_ret, i_target,
    output currentPC, o_depth, o_stackFull, o_stackEmpty, o_fault
  );
endinterface

// File: rtl/mcu_pc_sequencer.sv
// Program counter sequencer with a return-address stack.
// A stack overflow or underflow freezes the sequencer in a fault state, and only Reset clears that state.
module mcu_pc_sequencer #(
  parameter int PC_WIDTH    = 8,
  parameter int STACK_DEPTH = 4
) (
  input  logic               Clk,
  input  logic               Reset,
  mcu_pc_sequencer_if.slave  bus
);
  localparam int DW  = $clog2(STACK_DEPTH) + 1;
  localparam int SPW = $clog2(STACK_DEPTH);
  localparam logic [DW-1:0]       DEPTH_FULL = DW'(STACK_DEPTH);
  localparam logic [DW-1:0]       DEPTH_ONE  = DW'(1);
  localparam logic [PC_WIDTH-1:0] PC_ONE     = PC_WIDTH'(1);

  typedef enum logic {S_RUN, S_FAULT} state_e;

  state_e              state_q;
  logic [PC_WIDTH-1:0] pc_q;
  logic [DW-1:0]       depth_q;
  logic                fault_q;
  logic [PC_WIDTH-1:0] stack_q [STACK_DEPTH];

  logic [PC_WIDTH-1:0] pc_inc_d;
  logic [SPW-1:0]      push_idx_d;
  logic [SPW-1:0]      top_idx_d;

  // The increment wraps naturally. The stack index is the depth truncated to SPW bits.
  assign pc_inc_d   = pc_q + PC_ONE;
  assign push_idx_d = depth_q[SPW-1:0];
  assign top_idx_d  = push_idx_d - SPW'(1);

  // NOTE: sequential state uses non-blocking assignments, so every read in this block sees the pre-edge values.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      // NOTE: the stack array is deliberately left unreset. Clearing depth_q makes every entry unreachable until it is rewritten.
      pc_q    <= bus.resetPC;
      depth_q <= '0;
      fault_q <= 1'b0;
      state_q <= S_RUN;
    end else if (state_q == S_RUN) begin
      if (bus.i_stall) begin
        pc_q <= pc_q;
      end else if (bus.i_ret) begin
        // A call that arrives together with a ret is dropped silently.
        if (depth_q != '0) begin
          pc_q    <= stack_q[top_idx_d];
          depth_q <= depth_q - DEPTH_ONE;
        end else begin
          fault_q <= 1'b1;
          state_q <= S_FAULT;
        end
      end else if (bus.i_call) begin
        if (depth_q != DEPTH_FULL) begin
          stack_q[push_idx_d] <= pc_inc_d;
          depth_q             <= depth_q + DEPTH_ONE;
          pc_q                <= bus.i_target;
        end else begin
          fault_q <= 1'b1;
          state_q <= S_FAULT;
        end
      end else if (bus.i_jump) begin
        pc_q <= bus.i_target;
      end else begin
        pc_q <= pc_inc_d;
      end
    end
  end

  assign bus.currentPC    = pc_q;
  assign bus.o_depth      = depth_q;
  assign bus.o_fault      = fault_q;
  assign bus.o_stackFull  = (depth_q == DEPTH_FULL);
  assign bus.o_stackEmpty = (depth_q == '0);
endmodule

// File: tb/tb_mcu_pc_sequencer.sv
// Directed test of mcu_pc_sequencer (PC_WIDTH=8, STACK_DEPTH=4).
// A scoreboard queue decouples the stimulus from a per-cycle monitor.
module tb_mcu_pc_sequencer;
  typedef struct packed {
    logic [7:0] pc;
    logic [2:0] depth;
    logic       full;
    logic       empty;
    logic       fault;
  } obs_t;

  typedef struct {
    string name;
    obs_t  exp;
  } sb_item_t;

  logic Clk = 1'b0;
  logic Reset;
  int   total = 0;
  int   bad   = 0;
  sb_item_t sb_q[$];

  mcu_pc_sequencer_if #(.PC_WIDTH(8), .STACK_DEPTH(4)) bus ();

  mcu_pc_sequencer #(.PC_WIDTH(8), .STACK_DEPTH(4)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input obs_t act, input obs_t exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got pc=%h depth=%0d full=%b empty=%b fault=%b, expected pc=%h depth=%0d full=%b empty=%b fault=%b",
               name, act.pc, act.depth, act.full, act.empty, act.fault,
               exp.pc, exp.depth, exp.full, exp.empty, exp.fault);
    end
  endtask

  // Monitor: the DUT presents one new state after every rising edge.
  initial begin
    forever begin
      @(posedge Clk);
      #1;
      if (sb_q.size() != 0) begin
        sb_item_t it;
        obs_t     act;
        it  = sb_q.pop_front();
        act = '{pc: bus.currentPC, depth: bus.o_depth, full: bus.o_stackFull,
                empty: bus.o_stackEmpty, fault: bus.o_fault};
        check(it.name, act, it.exp);
      end
    end
  end

  // One cycle of stimulus. The expected state after the next rising edge goes to the scoreboard.
  task automatic step(input string name, input logic rst, input logic [7:0] rpc,
                      input logic stall, input logic ret, input logic call, input logic jump,
                      input logic [7:0] tgt,
                      input logic [7:0] e_pc, input logic [2:0] e_depth, input logic e_fault);
    sb_item_t it;
    @(negedge Clk);
    Reset        = rst;
    bus.resetPC  = rpc;
    bus.i_stall  = stall;
    bus.i_ret    = ret;
    bus.i_call   = call;
    bus.i_jump   = jump;
    bus.i_target = tgt;
    it.name = name;
    it.exp  = '{pc: e_pc, depth: e_depth, full: (e_depth == 3'd4),
                empty: (e_depth == 3'd0), fault: e_fault};
    sb_q.push_back(it);
  endtask

  task automatic idle(input string name, input logic [7:0] e_pc, input logic [2:0] e_depth,
                      input logic e_fault);
    step(name, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, e_pc, e_depth, e_fault);
  endtask

  task automatic rst(input string name, input logic [7:0] rpc);
    step(name, 1'b1, rpc, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, rpc, 3'd0, 1'b0);
  endtask

  initial begin
    Reset = 1'b1;
    bus.resetPC  = 8'h00;
    bus.i_stall  = 1'b0;
    bus.i_ret    = 1'b0;
    bus.i_call   = 1'b0;
    bus.i_jump   = 1'b0;
    bus.i_target = 8'h00;

    // Reset, then sequential increment
    rst ("reset_10", 8'h10);
    idle("inc_11", 8'h11, 3'd0, 1'b0);
    idle("inc_12", 8'h12, 3'd0, 1'b0);
    idle("inc_13", 8'h13, 3'd0, 1'b0);

    // Call, then return
    rst ("reset_20", 8'h20);
    step("call_80", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h80, 8'h80, 3'd1, 1'b0);
    idle("sub_81", 8'h81, 3'd1, 1'b0);
    idle("sub_82", 8'h82, 3'd1, 1'b0);
    step("ret_21", 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h21, 3'd0, 1'b0);
    idle("after_ret_22", 8'h22, 3'd0, 1'b0);

    // Nested calls; the immediate ret returns with no bubble
    rst ("reset_30a", 8'h30);
    step("nest_call_40", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h40, 8'h40, 3'd1, 1'b0);
    step("nest_call_50", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h50, 8'h50, 3'd2, 1'b0);
    step("nest_ret_41",  1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h41, 3'd1, 1'b0);
    step("nest_ret_31",  1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h31, 3'd0, 1'b0);

    // Fill the stack, overflow, and stay frozen in fault
    rst ("reset_30b", 8'h30);
    step("fill_call_40", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h40, 8'h40, 3'd1, 1'b0);
    step("fill_call_50", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h50, 8'h50, 3'd2, 1'b0);
    step("fill_call_60", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h60, 8'h60, 3'd3, 1'b0);
    step("fill_call_70", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h70, 8'h70, 3'd4, 1'b0);
    step("overflow_call", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h90, 8'h70, 3'd4, 1'b1);
    idle("fault_idle", 8'h70, 3'd4, 1'b1);
    step("fault_ret",  1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h70, 3'd4, 1'b1);
    step("fault_jump", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'hAA, 8'h70, 3'd4, 1'b1);

    // Reset with a full stack; stale entries must not come back
    rst ("reset_full_05", 8'h05);
    step("underflow_ret", 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h05, 3'd0, 1'b1);
    idle("underflow_hold", 8'h05, 3'd0, 1'b1);
    rst ("reset_fault_00", 8'h00);
    idle("post_fault_01", 8'h01, 3'd0, 1'b0);

    // PC wraparound, and a call at FF pushes 00
    rst ("reset_fe", 8'hFE);
    idle("wrap_ff", 8'hFF, 3'd0, 1'b0);
    idle("wrap_00", 8'h00, 3'd0, 1'b0);
    rst ("reset_fe2", 8'hFE);
    idle("pre_ff", 8'hFF, 3'd0, 1'b0);
    step("call_at_ff", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'hA0, 8'hA0, 3'd1, 1'b0);
    step("ret_to_00",  1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 3'd0, 1'b0);

    // Priority: reset over stall, stall over call, ret over call, call over jump
    step("reset_over_stall", 1'b1, 8'h10, 1'b1, 1'b0, 1'b1, 1'b0, 8'h99, 8'h10, 3'd0, 1'b0);
    step("stall_call",  1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h80, 8'h10, 3'd0, 1'b0);
    step("call_80b",    1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h80, 8'h80, 3'd1, 1'b0);
    step("call_and_ret", 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 8'h77, 8'h11, 3'd0, 1'b0);
    idle("inc_12b", 8'h12, 3'd0, 1'b0);
    step("stall_only",  1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h12, 3'd0, 1'b0);
    step("jump_c3",     1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'hC3, 8'hC3, 3'd0, 1'b0);
    step("stall_ret_empty", 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'hC3, 3'd0, 1'b0);
    step("call_over_jump", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 8'h55, 8'h55, 3'd1, 1'b0);
    step("ret_c4",      1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'hC4, 3'd0, 1'b0);
    step("ret_underflow2", 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'hC4, 3'd0, 1'b1);
    idle("fault_hold2", 8'hC4, 3'd0, 1'b1);
    rst ("final_reset", 8'h00);
    idle("final_inc", 8'h01, 3'd0, 1'b0);

    for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(posedge Clk);
    #2;
    if (sb_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d unchecked entries, expected 0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mcu_pc_sequencer.md
MCU_PC_SEQUENCER -- requirements
Module: mcu_pc_sequencer

Interface
REQ-001 Parameter PC_WIDTH, default 8, program counter and address width in bits (legal range 4..16).
REQ-002 Parameter STACK_DEPTH, default 4, number of return-address stack entries (power of two, 2..16).
REQ-003 Port Clk  input  1  system clock; all state updates on the rising edge.
REQ-004 Port Reset  input  1  reset, synchronous and active-high.
REQ-005 Port resetPC  input  PC_WIDTH  PC value loaded while Reset is high.
REQ-006 Port i_stall  input  1  when high, PC and stack hold.
REQ-007 Port i_jump  input  1  absolute jump request.
REQ-008 Port i_call  input  1  subroutine call request; pushes the return address.
REQ-009 Port i_ret  input  1  return request; pops the return address.
REQ-010 Port i_target  input  PC_WIDTH  destination for i_jump and i_call.
REQ-011 Port currentPC  output  PC_WIDTH  registered current program counter.
REQ-012 Port o_depth  output  clog2(STACK_DEPTH)+1  number of valid stack entries.
REQ-013 Port o_stackFull / o_stackEmpty  output  1 each  o_depth==STACK_DEPTH and o_depth==0 respectively (combinational from o_depth).
REQ-014 Port o_fault  output  1  sticky stack overflow/underflow flag.

Function
REQ-015 The block SHALL implement a two-state FSM: S_RUN (normal sequencing) and S_FAULT (PC frozen).
REQ-016 In S_RUN, each rising edge SHALL apply exactly one action, with priority i_stall > i_ret > i_call > i_jump > increment.
REQ-017 Stall: currentPC, stack and o_depth SHALL hold.
REQ-018 Ret with o_depth>0: currentPC SHALL take the top stack entry, and o_depth SHALL decrement by 1.
REQ-019 Call with o_depth<STACK_DEPTH: the stack SHALL push (currentPC+1) mod 2^PC_WIDTH, o_depth SHALL increment, and currentPC SHALL become i_target.
REQ-020 Jump: currentPC SHALL become i_target, with the stack unchanged.
REQ-021 Increment: currentPC SHALL become (currentPC+1) mod 2^PC_WIDTH; the all-ones value wraps to 0 with no flag.
REQ-022 All actions SHALL have a latency of one cycle: inputs sampled at edge N are visible on currentPC after edge N.
REQ-023 Ret with o_depth==0 (underflow) SHALL leave currentPC and the stack unchanged, set o_fault=1, and move to S_FAULT.
REQ-024 Call with o_depth==STACK_DEPTH (overflow) SHALL leave currentPC and the stack unchanged (no push, no overwrite), set o_fault=1, and move to S_FAULT.
REQ-025 A simultaneous i_call and i_ret SHALL be treated as ret only; the call is discarded without a fault.
REQ-026 In S_FAULT, currentPC, the stack and o_depth SHALL hold regardless of requests; only Reset exits S_FAULT.
REQ-027 A call followed immediately by a ret on the next cycle SHALL return to the pushed address with no bubble.

Reset
REQ-028 While Reset is high at a rising edge, the block SHALL set currentPC=resetPC, o_depth=0, o_fault=0 and state=S_RUN, overriding all requests including i_stall.
REQ-029 Reset asserted mid-sequence, including in S_FAULT or with a full stack, SHALL discard all stack contents; stale entries SHALL never be returned after reset.
REQ-030 On the first edge after Reset deasserts with no requests, currentPC SHALL become resetPC+1.

Verification (PC_WIDTH=8, STACK_DEPTH=4)
REQ-031 Reset with resetPC=8'h10, then 3 idle cycles -> currentPC reads 10, 11, 12, 13; o_depth=0; o_fault=0.
REQ-032 Start at PC=8'h20; call i_target=8'h80; 2 idle cycles; ret -> currentPC sequence 80, 81, 82, 21; o_depth goes 1 then 0.
REQ-033 Issue 4 nested calls, then a 5th call -> o_stackFull=1 after the 4th call; the 5th call leaves PC unchanged and sets o_fault=1; PC stays frozen until Reset.
REQ-034 Ret at o_depth=0 -> o_fault=1 and PC holds; assert Reset with resetPC=8'h00 -> o_fault=0 and currentPC=00.
REQ-035 Start at PC=8'hFE with no requests -> currentPC reads FF then 00; call issued at FF pushes 00.
REQ-036 Assert i_stall with i_call in the same cycle -> no change; i_call and i_ret together at o_depth=1 -> pop occurs and o_depth=0 with no fault.
